// File: rtl/stack_arb_pkg.sv
// Shared definitions for the stack request arbiter.
//   state_e           : arbiter FSM states (clear sequence, idle, service cycle)
//   OP_PUSH / OP_POP  : encoding of the per-requester op input
//   RST_*             : values the registered outputs take while rst is low
package stack_arb_pkg;

  typedef enum logic [2:0] {
    CLR_SETUP,
    CLR_STROBE,
    CLR_END,
    IDLE,
    SETUP,
    STROBE,
    COMMIT,
    RESP
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam state_e RST_STATE     = CLR_SETUP;
  localparam logic   RST_STK_CTL   = 1'b0;
  localparam logic   RST_STK_RST_N = 1'b0;
  localparam logic   RST_READY     = 1'b0;

endpackage

// File: rtl/stack_rr_pick.sv
// Combinational NREQ-way request picker.
//   req_i  : request vector
//   last_i : index of the requester served most recently
//   win_o  : one-hot winner (all zero when no request)
//   idx_o  : winner index (0 when no request)
// Build option STACK_ARB_PRIO_EN: fixed priority, requester 0 highest,
// last_i ignored. Otherwise round-robin starting after last_i.
module stack_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] win_o,
  output logic [IW-1:0]   idx_o
);

  // cand[gi] is the requester holding the gi-th highest priority.
  logic [IW-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
`ifdef STACK_ARB_PRIO_EN
      assign cand[gi] = IW'(gi);
`else
      assign cand[gi] = IW'((32'(last_i) + 32'(gi) + 32'd1) % 32'(NREQ));
`endif
    end
  endgenerate

`ifdef STACK_ARB_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;
`endif

  // Scan from lowest priority upward so the highest-priority requester
  // is the last assignment and wins.
  always_comb begin
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[cand[i]]) idx_o = cand[i];
    end
  end

  assign win_o = (|req_i) ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/stack_req_arbiter.sv
// Clocked front-end for a DEPTH-entry, DW-bit push/pop stack that commits
// on the falling edge of its ctl strobe. Clears the stack after reset,
// arbitrates push/pop requests from NREQ requesters, tracks depth locally
// and refuses pushes when full and pops when empty.
// Ports:
//   clk, rst (synchronous, active-low)
//   req/op/wdata    : per-requester request, op (1=push) and push data
//   gnt/done/err    : per-requester grant level, completion pulse, refusal flag
//   stk_w2/stk_w1   : push/pop levels to the stack
//   stk_din/stk_ctl : stack data and commit strobe
//   stk_rst_n       : stack clear level
//   depth/full/empty/ready : local occupancy and idle indication
// Build option STACK_ARB_PRIO_EN selects fixed priority instead of round-robin.
module stack_req_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 4,
  parameter int NREQ  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            op,
  input  logic [NREQ*DW-1:0]         wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            err,
  output logic                       stk_w2,
  output logic                       stk_w1,
  output logic [DW-1:0]              stk_din,
  output logic                       stk_ctl,
  output logic                       stk_rst_n,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ready
);

  localparam int DCW = $clog2(DEPTH + 1);
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   k_q;
  logic [DCW-1:0]  depth_q;
  logic [DCW-1:0]  depth_d;
  logic            full_q, empty_q;
  logic [NREQ-1:0] gnt_q, done_q, err_q;
  logic            w2_q, w1_q, ctl_q, rst_n_q, ready_q;
  logic [DW-1:0]   din_q;

  logic [DW-1:0]   wdata_a [NREQ];
  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            pick_op;
  logic            pick_legal;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_wdata
      assign wdata_a[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  stack_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (pick_win),
    .idx_o  (pick_idx)
  );

  assign pick_op    = op[pick_idx];
  assign pick_legal = (pick_op == OP_PUSH) ? !full_q : !empty_q;

  // w2_q still holds the latched op when the commit edge arrives.
  assign depth_d = w2_q ? (depth_q + DCW'(1)) : (depth_q - DCW'(1));

  // Outputs are set on the edge entering a state, so each registered
  // output is valid for exactly the cycle the FSM spends in that state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RST_STATE;
      last_q  <= '0;
      k_q     <= '0;
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      w2_q    <= 1'b0;
      w1_q    <= 1'b0;
      din_q   <= '0;
      ctl_q   <= RST_STK_CTL;
      rst_n_q <= RST_STK_RST_N;
      ready_q <= RST_READY;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        CLR_SETUP: begin
          ctl_q   <= 1'b1;
          state_q <= CLR_STROBE;
        end
        CLR_STROBE: begin
          ctl_q   <= 1'b0;  // stack clears on this fall
          state_q <= CLR_END;
        end
        CLR_END: begin
          rst_n_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        IDLE: begin
          if (|req) begin
            k_q     <= pick_idx;
            last_q  <= pick_idx;
            ready_q <= 1'b0;
            if (pick_legal) begin
              gnt_q   <= pick_win;
              w2_q    <= pick_op;
              w1_q    <= !pick_op;
              din_q   <= (pick_op == OP_PUSH) ? wdata_a[pick_idx] : '0;
              state_q <= SETUP;
            end else begin
              // Refused: answer immediately, the stack is never strobed.
              done_q  <= pick_win;
              err_q   <= pick_win;
              state_q <= RESP;
            end
          end
        end
        SETUP: begin
          ctl_q   <= 1'b1;
          state_q <= STROBE;
        end
        STROBE: begin
          ctl_q   <= 1'b0;  // stack commits on this fall
          depth_q <= depth_d;
          full_q  <= (depth_d == DCW'(DEPTH));
          empty_q <= (depth_d == '0);
          state_q <= COMMIT;
        end
        COMMIT: begin
          gnt_q   <= '0;
          w2_q    <= 1'b0;
          w1_q    <= 1'b0;
          din_q   <= '0;
          done_q  <= NREQ'(1) << k_q;
          state_q <= RESP;
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= CLR_SETUP;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign stk_w2    = w2_q;
  assign stk_w1    = w1_q;
  assign stk_din   = din_q;
  assign stk_ctl   = ctl_q;
  assign stk_rst_n = rst_n_q;
  assign depth     = depth_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_stack_req_arbiter.sv
// Self-checking bench for stack_req_arbiter (DEPTH=4, DW=4, NREQ=2).
// A waveform-script model predicts every output for every cycle; directed
// sequences pin latencies, depth values and grant order with literals.
module tb_stack_req_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] op = '0;
  logic [7:0] wdata = '0;
  logic [1:0] gnt, done, err;
  logic       stk_w2, stk_w1, stk_ctl, stk_rst_n, full, empty, ready;
  logic [3:0] stk_din;
  logic [2:0] depth;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_req_arbiter #(.DEPTH(4), .DW(4), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err),
    .stk_w2(stk_w2), .stk_w1(stk_w1), .stk_din(stk_din), .stk_ctl(stk_ctl),
    .stk_rst_n(stk_rst_n), .depth(depth), .full(full), .empty(empty),
    .ready(ready)
  );

  // ---------------- model: a queue of expected output frames ----------------
  typedef struct packed {
    logic [1:0] gnt, done, err;
    logic       w2, w1;
    logic [3:0] din;
    logic       ctl, rstn, ready;
    logic [2:0] depth;
    logic       full, empty;
  } frame_t;

  frame_t cur;
  frame_t fq[$];
  int     m_depth = 0;
  int     m_last = 0;
  bit     m_valid = 1'b0;

  function automatic frame_t mk(input logic [1:0] g, input logic [1:0] dn,
                                input logic [1:0] er, input logic w2,
                                input logic w1, input logic [3:0] din,
                                input logic ctl, input logic rn,
                                input logic rdy, input int dep);
    frame_t f;
    f.gnt = g; f.done = dn; f.err = er; f.w2 = w2; f.w1 = w1; f.din = din;
    f.ctl = ctl; f.rstn = rn; f.ready = rdy; f.depth = 3'(dep);
    f.full = (dep == 4); f.empty = (dep == 0);
    return f;
  endfunction

  function automatic int pick(input logic [1:0] r, input int last);
    int w = 0;
`ifdef STACK_ARB_PRIO_EN
    w = r[0] ? 0 : 1;
`else
    w = r[(last + 1) % 2] ? (last + 1) % 2 : last;
`endif
    return w;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1'b1;
      m_depth = 0;
      m_last  = 0;
      fq.delete();
      cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      fq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      fq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      fq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    end else if (m_valid) begin
      if (fq.size() == 0 && req != 2'b00) begin
        int         w, nd;
        logic       o;
        logic [3:0] d;
        logic [1:0] g;
        w = pick(req, m_last);
        m_last = w;
        o = op[w];
        d = wdata[w*4 +: 4];
        g = 2'(1 << w);
        if (o ? (m_depth < 4) : (m_depth > 0)) begin
          nd = o ? m_depth + 1 : m_depth - 1;
          if (!o) d = 4'h0;
          fq.push_back(mk(g, 0, 0, o, !o, d, 0, 1, 0, m_depth));
          fq.push_back(mk(g, 0, 0, o, !o, d, 1, 1, 0, m_depth));
          fq.push_back(mk(g, 0, 0, o, !o, d, 0, 1, 0, nd));
          fq.push_back(mk(0, g, 0, 0, 0, 0, 0, 1, 0, nd));
          fq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, nd));
          m_depth = nd;
        end else begin
          fq.push_back(mk(0, g, g, 0, 0, 0, 0, 1, 0, m_depth));
          fq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, m_depth));
        end
      end
      if (fq.size() > 0) cur = fq.pop_front();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      frame_t act;
      act.gnt = gnt; act.done = done; act.err = err; act.w2 = stk_w2;
      act.w1 = stk_w1; act.din = stk_din; act.ctl = stk_ctl;
      act.rstn = stk_rst_n; act.ready = ready; act.depth = depth;
      act.full = full; act.empty = empty;
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL cycle_frame t=%0t actual=%h required=%h", $time, act, cur);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic reset_seq(input int n);
    rst = 1'b0;
    req = '0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
    check("rstn_p1", int'(stk_rst_n), 0);
    @(negedge clk);
    check("ctl_p2", int'(stk_ctl), 1);
    check("rstn_p2", int'(stk_rst_n), 0);
    @(negedge clk);
    check("ctl_p3", int'(stk_ctl), 0);
    check("ready_p3", int'(ready), 0);
    @(negedge clk);
    check("ready_p4", int'(ready), 1);
    check("rstn_p4", int'(stk_rst_n), 1);
    check("depth_p4", int'(depth), 0);
    check("empty_p4", int'(empty), 1);
    $display("reset: clear sequence done, depth=%0d ready=%0d", depth, ready);
  endtask

  task automatic do_op(input int idx, input logic o, input logic [3:0] d,
                       output int lat, output int gcnt, output int ccnt,
                       output int e);
    int t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 0, 1);
    req[idx] = 1'b1;
    op[idx] = o;
    wdata[idx*4 +: 4] = d;
    lat = 0; gcnt = 0; ccnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (gnt[idx]) gcnt++;
      if (stk_ctl) ccnt++;
    end while (!done[idx] && lat < 20);
    if (!done[idx]) check("done_timeout", 0, 1);
    e = int'(err[idx]);
    req[idx] = 1'b0;
    $display("op: req%0d %s data=%h lat=%0d gnt_cycles=%0d err=%0d depth=%0d",
             idx, o ? "push" : "pop", d, lat, gcnt, e, depth);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gc, cc, e;
    int order[4];
    int rem[2];
    int n, cyc;

    reset_seq(3);

    // single push of A then pop it back
    do_op(0, 1'b1, 4'hA, lat, gc, cc, e);
    check("push_lat", lat, 4);
    check("push_gnt_cycles", gc, 3);
    check("push_ctl_cycles", cc, 1);
    check("push_err", e, 0);
    check("push_depth", int'(depth), 1);
    do_op(0, 1'b0, 4'h0, lat, gc, cc, e);
    check("pop_lat", lat, 4);
    check("pop_depth", int'(depth), 0);

    // fill to full, then overflow
    for (int i = 1; i <= 4; i++) do_op(0, 1'b1, 4'(i), lat, gc, cc, e);
    check("fill_depth", int'(depth), 4);
    check("fill_full", int'(full), 1);
    do_op(0, 1'b1, 4'h5, lat, gc, cc, e);
    check("ovf_lat", lat, 1);
    check("ovf_err", e, 1);
    check("ovf_ctl_cycles", cc, 0);
    check("ovf_gnt_cycles", gc, 0);
    check("ovf_depth", int'(depth), 4);

    // drain, then underflow from requester 1
    for (int i = 0; i < 4; i++) do_op(0, 1'b0, 4'h0, lat, gc, cc, e);
    check("drain_empty", int'(empty), 1);
    do_op(1, 1'b0, 4'h0, lat, gc, cc, e);
    check("unf_lat", lat, 1);
    check("unf_err", e, 1);
    check("unf_ctl_cycles", cc, 0);
    check("unf_depth", int'(depth), 0);

    // contention: both requesters want two pushes each
    @(negedge clk);
    op = 2'b11;
    wdata = 8'h65;
    req = 2'b11;
    rem[0] = 2; rem[1] = 2; n = 0; cyc = 0;
    while ((rem[0] + rem[1]) > 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (done[i] && n < 4) begin
          order[n] = i;
          n++;
          rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
          $display("contention: done%0d (#%0d) depth=%0d", i, n, depth);
        end
      end
    end
    req = '0;
    check("cont_count", n, 4);
`ifdef STACK_ARB_PRIO_EN
    check("cont_order0", order[0], 0);
    check("cont_order1", order[1], 0);
    check("cont_order2", order[2], 1);
    check("cont_order3", order[3], 1);
`else
    check("cont_order0", order[0], 0);
    check("cont_order1", order[1], 1);
    check("cont_order2", order[2], 0);
    check("cont_order3", order[3], 1);
`endif
    check("cont_depth", int'(depth), 4);

    // reset during STROBE of a pop
    @(negedge clk);
    op[0] = 1'b0;
    req[0] = 1'b1;
    cyc = 0;
    while (!stk_ctl && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("midop_strobe_seen", int'(stk_ctl), 1);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    check("midop_ctl", int'(stk_ctl), 0);
    check("midop_gnt", int'(gnt), 0);
    check("midop_depth", int'(depth), 0);
    $display("midop reset: ctl=%0d gnt=%0d depth=%0d", stk_ctl, gnt, depth);
    reset_seq(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
